// File: rtl/sb_xform_pkg.sv
// Shared types and the per-lane arithmetic for the switchboard lane transform.
// Contents: xform_mode_t lane op encoding, XF_MAXW widest lane supported, lane_op().
package sb_xform_pkg;

    // Widest lane lane_op() handles; callers zero-extend and truncate.
    localparam int XF_MAXW = 64;

    typedef enum logic [1:0] {
        XF_ADD  = 2'd0,
        XF_SUB  = 2'd1,
        XF_XOR  = 2'd2,
        XF_PASS = 2'd3
    } xform_mode_t;

    // Low LW bits of the result are the lane value modulo 2^LW.
    function automatic logic [XF_MAXW-1:0] lane_op(
        input xform_mode_t        mode,
        input logic [XF_MAXW-1:0] x,
        input logic [XF_MAXW-1:0] op
    );
        logic [XF_MAXW-1:0] r;
        r = x;
        unique case (mode)
            XF_ADD:  r = x + op;
            XF_SUB:  r = x - op;
            XF_XOR:  r = x ^ op;
            XF_PASS: r = x;
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_skid_buf.sv
// Generic 2-entry valid/ready buffer; o_ready depends on registered occupancy only.
// Ports: clk, rst (sync, active-high), i_data/i_valid/o_ready upstream, o_data/o_valid/i_ready downstream.
module sb_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_ready = ~r_cnt[1];
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rp];

    assign w_push = i_valid & o_ready;
    assign w_pop  = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            // Push and pop together leave occupancy unchanged.
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/sb_lane_xform.sv
// Switchboard stream transform: per-lane ADD/SUB/XOR/PASS, dest/last passed through, sentinel flag.
// Ports: cfg_mode/cfg_operand, in_* and out_* SB streams, done, pkt_count/beat_count (SB_LANE_XFORM_STATS_EN).
import sb_xform_pkg::*;

module sb_lane_xform #(
    parameter int DW = 256,
    parameter int LW = 8,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    cfg_mode,
    input  logic [LW-1:0] cfg_operand,
    input  logic [DW-1:0] in_data,
    input  logic [31:0]   in_dest,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic [31:0]   out_dest,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          done,
    output logic [CW-1:0] pkt_count,
    output logic [CW-1:0] beat_count
);

    localparam int NL = DW / LW;
    localparam int W  = DW + 32 + 1;

    if (DW % LW != 0) begin : g_bad_dw
        $error("sb_lane_xform: DW must be a multiple of LW");
    end
    if (LW > XF_MAXW) begin : g_bad_lw
        $error("sb_lane_xform: LW exceeds XF_MAXW");
    end

    logic [DW-1:0] w_xdata;
    logic [W-1:0]  w_out;
    logic          w_acc;
    logic          w_emit;
    logic          r_done;

    // Transform before buffering so cfg is captured with each accepted beat.
    always_comb begin
        w_xdata = '0;
        for (int i = 0; i < NL; i++) begin
            w_xdata[i*LW +: LW] = LW'(lane_op(
                xform_mode_t'(cfg_mode),
                XF_MAXW'(in_data[i*LW +: LW]),
                XF_MAXW'(cfg_operand)));
        end
    end

    sb_skid_buf #(
        .W(W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({in_dest, in_last, w_xdata}),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_data  (w_out),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

    assign out_dest = w_out[W-1 -: 32];
    assign out_last = w_out[DW];
    assign out_data = w_out[DW-1:0];

    assign w_acc  = in_valid & in_ready;
    assign w_emit = out_valid & out_ready;

    // Sentinel is judged on the raw beat, not the transformed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else if (w_acc && (&in_data)) begin
            r_done <= 1'b1;
        end
    end

    assign done = r_done;

`ifdef SB_LANE_XFORM_STATS_EN
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] r_pkt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else if (w_emit) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
            if (out_last) begin
                r_pkt_cnt <= r_pkt_cnt + CW'(1);
            end
        end
    end

    assign beat_count = r_beat_cnt;
    assign pkt_count  = r_pkt_cnt;
`else
    logic w_unused_emit;
    assign w_unused_emit = w_emit;
    assign beat_count    = '0;
    assign pkt_count     = '0;
`endif

endmodule
